msg_serial_tx: RTL and testbench

Serializes a latched message word onto a single output line, one bit per tick of the programmable frequency divider. It sits directly downstream of the frequency-divider stage and consumes its carry-out pulse as the bit-rate strobe. It drives the divider's load input at frame start so that every frame begins on a fresh divider period.

---
 rtl/msg_serial_tx.sv | 148 ++++++++++++++
 tb/tb_msg_serial_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/msg_serial_tx.sv
// ============================================================================
// Module      : msg_serial_tx
// Description : Frames a latched message word (start, data LSB first,
//               optional even parity, stop) onto a single serial line, one
//               bit per divider tick. Parity is enabled by defining
//               MSG_SERIAL_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_serial_tx #(
    parameter int MSG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [MSG_W-1:0] msg,
    output logic             init,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(MSG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef MSG_SERIAL_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [MSG_W-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_init;
    logic               r_sout;
    logic               r_busy;
    logic               r_done;
`ifdef MSG_SERIAL_PARITY_EN
    logic               r_parity;
`endif

    logic               w_tick;
    logic [MSG_W-1:0]   w_shift_nxt;

    // The divider is being reloaded while init is high, so its carry-out
    // in that cycle belongs to the previous period and must not count.
    assign w_tick      = tick & ~r_init;
    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_init   <= 1'b0;
            r_sout   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MSG_SERIAL_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_init <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift  <= msg;
                        r_cnt    <= '0;
                        r_state  <= S_START;
                        r_sout   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_init   <= 1'b1;
`ifdef MSG_SERIAL_PARITY_EN
                        r_parity <= ^msg;
`endif
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_sout  <= r_shift[0];
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= w_shift_nxt;
                        // The counter stops at the last index so it never
                        // wraps when MSG_W is a power of two.
                        if (r_cnt == c_LAST_BIT) begin
`ifdef MSG_SERIAL_PARITY_EN
                            r_state <= S_PARITY;
                            r_sout  <= r_parity;
`else
                            r_state <= S_STOP;
                            r_sout  <= 1'b1;
`endif
                        end else begin
                            r_cnt  <= r_cnt + 1'b1;
                            r_sout <= w_shift_nxt[0];
                        end
                    end
                end

`ifdef MSG_SERIAL_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_sout  <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_sout  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_sout  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign init = r_init;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_msg_serial_tx.sv
// ============================================================================
// Module      : tb_msg_serial_tx
// Description : Self-checking bench for msg_serial_tx (MSG_W = 5): vector
//               table plus directed multi-cycle frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_serial_tx;

    localparam int MSG_W = 5;
`ifdef MSG_SERIAL_PARITY_EN
    localparam int c_FRAME = MSG_W + 3;
`else
    localparam int c_FRAME = MSG_W + 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             start;
    logic [MSG_W-1:0] msg;
    logic             init;
    logic             sout;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    msg_serial_tx #(.MSG_W(MSG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .start (start),
        .msg   (msg),
        .init  (init),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v_rst;
        logic             v_start;
        logic             v_tick;
        logic [MSG_W-1:0] v_msg;
        logic             e_sout;
        logic             e_busy;
        logic             e_init;
        logic             e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic t,
                                input logic [MSG_W-1:0] m, input logic eo,
                                input logic eb, input logic ei, input logic ed);
        vec_t v;
        v.v_rst = r; v.v_start = s; v.v_tick = t; v.v_msg = m;
        v.e_sout = eo; v.e_busy = eb; v.e_init = ei; v.e_done = ed;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Expected line level for each bit slot of a frame carrying m.
    function automatic void frame_bits(input logic [MSG_W-1:0] m, output logic b [c_FRAME]);
        b[0] = 1'b0;
        for (int i = 0; i < MSG_W; i++) b[i+1] = m[i];
`ifdef MSG_SERIAL_PARITY_EN
        b[MSG_W+1] = ^m;
`endif
        b[c_FRAME-1] = 1'b1;
    endfunction

    // Accepts m on the next edge, ticks every per cycles (optionally also in
    // the init cycle) and checks every cycle through the done pulse.
    // Returns in the done cycle with start/msg left as the frame had them.
    task automatic send_frame(input logic [MSG_W-1:0] m, input int per,
                              input bit keep_start, input logic [MSG_W-1:0] m_late,
                              input bit init_tick, input string tag);
        logic b [c_FRAME];
        frame_bits(m, b);
        start = 1'b1;
        msg   = m;
        tick  = 1'b0;
        step();
        if (!keep_start) start = 1'b0;
        msg = m_late;
        for (int k = 1; k <= c_FRAME * per; k++) begin
            check({tag, " sout"}, sout, b[(k-1)/per]);
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " init"}, init, (k == 1));
            check({tag, " done"}, done, 1'b0);
            tick = ((k % per) == 0) || (init_tick && k == 1);
            step();
        end
        tick = 1'b0;
        check({tag, " done pulse"}, done, 1'b1);
        check({tag, " busy end"}, busy, 1'b0);
        check({tag, " sout end"}, sout, 1'b1);
        check({tag, " init end"}, init, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; msg = '0;

        // Vector table: reset, tick in idle, then a frame of 10110 with tick
        // held high every cycle (the tick in the init cycle is discarded).
        add(1, 0, 0, 5'b00000, 1, 0, 0, 0);
        add(1, 1, 1, 5'b11111, 1, 0, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 0, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 0, 0, 0);
        add(0, 1, 1, 5'b10110, 0, 1, 1, 0);
        add(0, 0, 1, 5'b00000, 0, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 0, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 0, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 1, 0, 0);
`ifdef MSG_SERIAL_PARITY_EN
        add(0, 0, 1, 5'b00000, 1, 1, 0, 0);
`endif
        add(0, 0, 1, 5'b00000, 1, 1, 0, 0);
        add(0, 0, 1, 5'b00000, 1, 0, 0, 1);
        add(0, 0, 1, 5'b00000, 1, 0, 0, 0);
        add(0, 0, 0, 5'b00000, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            rst   = vecs[i].v_rst;
            start = vecs[i].v_start;
            tick  = vecs[i].v_tick;
            msg   = vecs[i].v_msg;
            step();
            check($sformatf("vec%0d sout", i), sout, vecs[i].e_sout);
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d init", i), init, vecs[i].e_init);
            check($sformatf("vec%0d done", i), done, vecs[i].e_done);
        end

        // Basic frame, tick every 4 cycles.
        send_frame(5'b10110, 4, 1'b0, 5'b10110, 1'b0, "basic");
        step();

        // Tick coincident with init is ignored; START still lasts 4 cycles.
        send_frame(5'b01101, 4, 1'b0, 5'b01101, 1'b1, "init_tick");
        step();

        // Start held through the frame, msg changed after acceptance, then a
        // second frame accepted in the done cycle.
        send_frame(5'b10110, 4, 1'b1, 5'b00001, 1'b0, "b2b_first");
        send_frame(5'b00001, 3, 1'b0, 5'b11111, 1'b0, "b2b_second");
        step();

        // Reset during data bit 2 (frame slot 3, cycles k = 13..16).
        begin
            logic b [c_FRAME];
            frame_bits(5'b10110, b);
            start = 1'b1; msg = 5'b10110; tick = 1'b0;
            step();
            start = 1'b0;
            for (int k = 1; k <= 14; k++) begin
                check("rst_mid sout", sout, b[(k-1)/4]);
                tick = ((k % 4) == 0);
                step();
            end
            check("rst_mid in data2", sout, b[3]);
            rst = 1'b1; tick = 1'b0;
            step();
            check("rst_mid sout", sout, 1'b1);
            check("rst_mid busy", busy, 1'b0);
            check("rst_mid done", done, 1'b0);
            check("rst_mid init", init, 1'b0);
            rst = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                tick = ((k % 4) == 0);
                step();
                check("post_rst done", done, 1'b0);
                check("post_rst busy", busy, 1'b0);
                check("post_rst sout", sout, 1'b1);
            end
        end
        send_frame(5'b10011, 2, 1'b0, 5'b00000, 1'b0, "after_rst");
        step();
        check("final idle busy", busy, 1'b0);
        check("final idle done", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
